// File: rtl/oven_pkg.sv
// -----------------------------------------------------------------------------
// oven_pkg
// Shared definitions for the microwave cook-timer control path.
//   - state_t / ST_* : 3-bit FSM state codes, also shown on the debug display
//   - TICK_DIV_DEFAULT   : clock cycles per 1 Hz tick at the board clock
//   - BEEP_TICKS_DEFAULT : seconds the done beeper sounds
// -----------------------------------------------------------------------------
package oven_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned TICK_DIV_DEFAULT   = 50_000_000;
  localparam int unsigned BEEP_TICKS_DEFAULT = 3;

endpackage

// File: rtl/oven_timer_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running 1 Hz tick divider: counts 0 .. TICK_DIV-1 and wraps.
// Ports:
//   clock   in  system clock
//   clear   in  synchronous active-high reset, zeroes the count
//   restart in  zeroes the count on the next edge (phase-align a new second)
//   tick    out high for the single cycle where count == TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen
  import oven_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + W'(1);
    if (restart || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/oven_timer_ctrl.sv
// -----------------------------------------------------------------------------
// oven_timer_ctrl
// Control FSM for the microwave cook timer. Clears/loads the cascaded
// down-counter chain, issues one count enable per second while cooking, and
// drives the magnetron and done beeper behind the door interlock.
// Ports:
//   clock, clear          clock and synchronous active-high reset
//   key_valid/start/stop/cancel  one-cycle keypad pulses
//   door_closed           interlock, 1 = closed
//   time_zero             all counter-chain digits are zero
//   cnt_clearn/cnt_loadn  active-low clear/load to the chain
//   cnt_en                one-cycle decrement enable to the chain
//   mag_on, beep          magnetron and beeper drives
//   state                 current state code
// All outputs are registered (one cycle latency from the sampled inputs).
// -----------------------------------------------------------------------------
module oven_timer_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int unsigned BEEP_TICKS = BEEP_TICKS_DEFAULT
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       time_zero,
  output logic       cnt_clearn,
  output logic       cnt_loadn,
  output logic       cnt_en,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  localparam int unsigned BW = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

  state_t        state_q, state_d;
  logic          clearn_q, clearn_d;
  logic          loadn_q, loadn_d;
  logic          en_q, en_d;
  logic          mag_q;
  logic          beep_q;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          tick;
  logic          restart;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock   (clock),
    .clear   (clear),
    .restart (restart),
    .tick    (tick)
  );

  // Priority inside each state: cancel > door open / stop > start
  // > key_valid > tick.
  always_comb begin
    state_d    = state_q;
    clearn_d   = 1'b1;
    loadn_d    = 1'b1;
    en_d       = 1'b0;
    beep_cnt_d = beep_cnt_q;
    restart    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          clearn_d = 1'b0;
        end else if (key_valid) begin
          state_d = ST_SET;
          loadn_d = 1'b0;
        end
      end
      ST_SET: begin
        if (cancel) begin
          state_d  = ST_IDLE;
          clearn_d = 1'b0;
        end else if (start && door_closed && !time_zero) begin
          state_d = ST_RUN;
        end else if (key_valid) begin
          loadn_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d  = ST_IDLE;
          clearn_d = 1'b0;
        end else if (!door_closed || stop) begin
          state_d = ST_PAUSE;
        end else if (time_zero) begin
          // The chain wraps 0 -> 5, so a coincident tick must not count.
          state_d = ST_DONE;
        end else if (tick) begin
          en_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cancel || stop) begin
          state_d  = ST_IDLE;
          clearn_d = 1'b0;
        end else if (start && door_closed) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (cancel || start || stop || key_valid || !door_closed) begin
          state_d  = ST_IDLE;
          clearn_d = 1'b0;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_LAST) begin
            state_d  = ST_IDLE;
            clearn_d = 1'b0;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        clearn_d = 1'b0;
      end
    endcase

    // Re-phase the divider when a timed state is entered so each second
    // (cook decrement or beep second) is a full TICK_DIV cycles long.
    if ((state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_DONE))) begin
      restart = 1'b1;
    end
    if ((state_d != state_q) && (state_d == ST_DONE)) begin
      beep_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      clearn_q   <= 1'b0;
      loadn_q    <= 1'b1;
      en_q       <= 1'b0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clearn_q   <= clearn_d;
      loadn_q    <= loadn_d;
      en_q       <= en_d;
      mag_q      <= (state_d == ST_RUN);
      beep_q     <= (state_d == ST_DONE);
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign cnt_clearn = clearn_q;
  assign cnt_loadn  = loadn_q;
  assign cnt_en     = en_q;
  assign mag_on     = mag_q;
  assign beep       = beep_q;
  assign state      = state_q;

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oven_timer_ctrl
// Directed scenarios followed by a randomized phase. A behavioural model
// predicts every output each cycle; the counter chain is modelled as a plain
// seconds down-counter that reacts to the DUT's clear/load/enable.
// -----------------------------------------------------------------------------
module tb_oven_timer_ctrl;

  localparam int TDIV  = 4;
  localparam int BEEPT = 3;
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       key_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cancel = 1'b0;
  logic       door_closed = 1'b1;
  logic       time_zero = 1'b1;
  logic       cnt_clearn, cnt_loadn, cnt_en, mag_on, beep;
  logic [2:0] state;

  oven_timer_ctrl #(.TICK_DIV(TDIV), .BEEP_TICKS(BEEPT)) dut (
    .clock       (clock),
    .clear       (clear),
    .key_valid   (key_valid),
    .start       (start),
    .stop        (stop),
    .cancel      (cancel),
    .door_closed (door_closed),
    .time_zero   (time_zero),
    .cnt_clearn  (cnt_clearn),
    .cnt_loadn   (cnt_loadn),
    .cnt_en      (cnt_en),
    .mag_on      (mag_on),
    .beep        (beep),
    .state       (state)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Environment: counter chain in whole seconds, digit presented on the bus.
  int chain    = 0;
  int load_val = 0;
  int pend_val = 0;

  // Model: n is the index of the upcoming clock edge.
  int   n         = 0;
  int   m_state   = M_IDLE;
  int   sec_edge  = 0;   // edge at which the current second started
  int   done_edge = 0;   // edge at which DONE was entered
  logic e_clr = 1'b0, e_ld = 1'b1, e_en = 1'b0, e_mag = 1'b0, e_beep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // One clock: apply pulses, predict, advance, update chain, compare.
  task automatic cycle(input logic kv, input logic st, input logic sp, input logic cn);
    logic pre_clr, pre_ld, pre_en, sec_over;
    int   nm;
    key_valid = kv; start = st; stop = sp; cancel = cn;

    // A second ends on every TDIV-th edge after the last re-phase.
    sec_over = ((n - sec_edge) % TDIV) == 0;
    nm = m_state; e_clr = 1'b1; e_ld = 1'b1; e_en = 1'b0;
    if (clear) begin
      nm = M_IDLE; e_clr = 1'b0; sec_edge = n;
    end else begin
      case (m_state)
        M_IDLE:  if (cn) e_clr = 1'b0;
                 else if (kv) begin nm = M_SET; e_ld = 1'b0; end
        M_SET:   if (cn) begin nm = M_IDLE; e_clr = 1'b0; end
                 else if (st && door_closed && !time_zero) nm = M_RUN;
                 else if (kv) e_ld = 1'b0;
        M_RUN:   if (cn) begin nm = M_IDLE; e_clr = 1'b0; end
                 else if (!door_closed || sp) nm = M_PAUSE;
                 else if (time_zero) nm = M_DONE;
                 else if (sec_over) e_en = 1'b1;
        M_PAUSE: if (cn || sp) begin nm = M_IDLE; e_clr = 1'b0; end
                 else if (st && door_closed) nm = M_RUN;
        default: if (cn || st || sp || kv || !door_closed) begin nm = M_IDLE; e_clr = 1'b0; end
                 else if (sec_over && (n - done_edge) >= BEEPT * TDIV) begin
                   nm = M_IDLE; e_clr = 1'b0;
                 end
      endcase
      if (nm != m_state && (nm == M_RUN || nm == M_DONE)) sec_edge = n;
      if (nm != m_state && nm == M_DONE) done_edge = n;
    end
    e_mag  = (nm == M_RUN);
    e_beep = (nm == M_DONE);

    pre_clr = cnt_clearn; pre_ld = cnt_loadn; pre_en = cnt_en;
    @(posedge clock);
    #1;
    if (pre_clr === 1'b0) chain = 0;
    else if (pre_ld === 1'b0) chain = pend_val;
    else if (pre_en === 1'b1) chain = (chain == 0) ? 5 : chain - 1;
    if (kv) pend_val = load_val;
    time_zero = (chain == 0);
    m_state = nm;
    n++;

    chk("state", 32'(state), 32'(nm));
    chk("cnt_clearn", 32'(cnt_clearn), 32'(e_clr));
    chk("cnt_loadn", 32'(cnt_loadn), 32'(e_ld));
    chk("cnt_en", 32'(cnt_en), 32'(e_en));
    chk("mag_on", 32'(mag_on), 32'(e_mag));
    chk("beep", 32'(beep), 32'(e_beep));
    chk("load_en_excl", 32'(!(cnt_loadn === 1'b0 && cnt_en === 1'b1)), 32'(1));
    $display("[TB] edge %0d kv=%0b st=%0b sp=%0b cn=%0b door=%0b st_code=%0d en=%0b mag=%0b beep=%0b chain=%0d",
             n - 1, kv, st, sp, cn, door_closed, state, cnt_en, mag_on, beep, chain);
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input int secs);
    load_val = secs;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  initial begin
    int s, en_cnt, beep_cycles, seen_done, finished, en_seen;
    int en_pos[3];

    // 1. Reset held for two edges, then released.
    clear = 1'b1;
    idle(2);
    chk("rst_state", 32'(state), 32'(M_IDLE));
    chk("rst_clearn", 32'(cnt_clearn), 32'(0));
    chk("rst_mag", 32'(mag_on), 32'(0));
    chk("rst_beep", 32'(beep), 32'(0));
    clear = 1'b0;
    idle(1);
    chk("rel_clearn", 32'(cnt_clearn), 32'(1));

    // 2. Load 3 s and run to completion.
    door_closed = 1'b1;
    load_val = 3;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_pulse", 32'(cnt_loadn), 32'(0));
    chk("load_state", 32'(state), 32'(M_SET));
    idle(1);
    chk("load_release", 32'(cnt_loadn), 32'(1));
    s = n;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_run", 32'(state), 32'(M_RUN));
    en_cnt = 0; beep_cycles = 0; seen_done = 0; finished = 0;
    for (int k = 0; k < 40 && finished == 0; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (cnt_en === 1'b1) begin
        if (en_cnt < 3) en_pos[en_cnt] = n - 1 - s;
        en_cnt++;
      end
      if (beep === 1'b1) beep_cycles++;
      if (state === 3'(M_DONE) && seen_done == 0) begin
        seen_done = 1;
        chk("done_mag_off", 32'(mag_on), 32'(0));
      end
      if (seen_done == 1 && state === 3'(M_IDLE)) begin
        finished = 1;
        chk("done_exit_clearn", 32'(cnt_clearn), 32'(0));
      end
    end
    chk("run_finished", 32'(finished), 32'(1));
    chk("en_count", 32'(en_cnt), 32'(3));
    chk("en_pos0", 32'(en_pos[0]), 32'(4));
    chk("en_pos1", 32'(en_pos[1]), 32'(8));
    chk("en_pos2", 32'(en_pos[2]), 32'(12));
    chk("beep_len", 32'(beep_cycles), 32'(BEEPT * TDIV));

    // 3. Door interlock.
    load(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    door_closed = 1'b0;
    idle(1);
    chk("door_pause", 32'(state), 32'(M_PAUSE));
    chk("door_mag", 32'(mag_on), 32'(0));
    en_seen = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (cnt_en !== 1'b0) en_seen++;
    end
    chk("door_no_en", 32'(en_seen), 32'(0));
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("door_open_start", 32'(state), 32'(M_PAUSE));
    door_closed = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("door_resume", 32'(state), 32'(M_RUN));
    chk("door_resume_mag", 32'(mag_on), 32'(1));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // 4. Zero guard: start at zero, then zero coincident with a tick.
    load(0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_start_state", 32'(state), 32'(M_SET));
    chk("zero_start_mag", 32'(mag_on), 32'(0));
    load(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chain = 0; time_zero = 1'b1;
    idle(1);
    chk("zero_tick_state", 32'(state), 32'(M_DONE));
    chk("zero_tick_en", 32'(cnt_en), 32'(0));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // 5. cancel beats start in SET.
    load(4);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("prio_state", 32'(state), 32'(M_IDLE));
    chk("prio_clearn", 32'(cnt_clearn), 32'(0));
    chk("prio_mag", 32'(mag_on), 32'(0));

    // 6. Reset in the middle of cooking.
    load(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    clear = 1'b1;
    idle(1);
    chk("midrst_state", 32'(state), 32'(M_IDLE));
    chk("midrst_mag", 32'(mag_on), 32'(0));
    clear = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (cnt_en !== 1'b0) en_seen++;
    end
    chk("midrst_no_en", 32'(en_seen), 32'(0));

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic kv, st, sp, cn;
      if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
      clear = ($urandom_range(0, 149) == 0);
      kv = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 24) == 0);
      cn = ($urandom_range(0, 39) == 0);
      if (kv) load_val = int'($urandom_range(0, 6));
      cycle(kv, st, sp, cn);
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/oven_timer_ctrl.md
Name: oven_timer_ctrl

Overview:
- Control FSM for the microwave cook timer.
- Sequences the cascaded down-counter chain (seconds units, seconds tens, minutes): clears it, loads it from keypad digits, and enables one decrement per second.
- Drives the magnetron and the done beeper, gated by the door interlock.
- Sits between the keypad/door front end and the counter chain. Contains its own 1 Hz tick divider.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per 1 Hz tick; must be ≥ 2.
- BEEP_TICKS, 3: number of ticks the beeper stays on in DONE; must be ≥ 1.

Ports:
- clock  in  1  system clock
- clear  in  1  reset; synchronous, active-high
- key_valid  in  1  one-cycle pulse: keypad digit present on the chain's data bus
- start  in  1  one-cycle pulse: start key
- stop  in  1  one-cycle pulse: pause key
- cancel  in  1  one-cycle pulse: cancel/clear key
- door_closed  in  1  1 = door closed (interlock)
- time_zero  in  1  AND of all counter-chain zero flags
- cnt_clearn  out  1  active-low clear to the chain
- cnt_loadn  out  1  active-low load to the chain
- cnt_en  out  1  count enable to the chain
- mag_on  out  1  magnetron drive
- beep  out  1  beeper drive
- state  out  3  current state code (debug/display)

Behaviour:
- All outputs are registered. Each output reflects decisions made from inputs sampled on the previous edge, so latency is 1 cycle.
- Reset (clear=1 at an edge):
  - state = IDLE, cnt_clearn = 0, cnt_loadn = 1, cnt_en = 0, mag_on = 0, beep = 0.
  - Tick divider and beep counter are zeroed.
  - Reset mid-RUN drops mag_on on the same edge.
  - On the first edge with clear=0, cnt_clearn returns to 1.
- State codes: IDLE = 0, SET = 1, RUN = 2, PAUSE = 3, DONE = 4.
- Tick divider:
  - Free-running counter from 0 to TICK_DIV-1, then wraps.
  - Internal tick is 1 for the single cycle where the count equals TICK_DIV-1.
  - Divider is reset to 0 on entry to RUN, so the first decrement occurs a full second after start.
- Event priority within one cycle: cancel > door open / stop > start > key_valid > tick.
- IDLE:
  - key_valid → SET; cnt_loadn = 0 for 1 cycle.
  - start, stop and tick are ignored.
- SET:
  - key_valid → stay in SET; cnt_loadn = 0 for 1 cycle.
  - cancel → IDLE; cnt_clearn = 0 for 1 cycle.
  - start with door_closed=1 and time_zero=0 → RUN.
  - start with door open or time_zero=1 → ignored.
- RUN:
  - mag_on = 1.
  - On tick with time_zero=0: cnt_en = 1 for exactly 1 cycle.
  - cnt_en is never asserted while time_zero=1. The chain wraps 0→5, so this is mandatory.
  - time_zero=1 → DONE; mag_on = 0 on the same edge. Applies even if tick coincides; in that case no cnt_en is issued.
  - door_closed=0 or stop → PAUSE; mag_on = 0, counters hold.
  - cancel → IDLE; cnt_clearn pulse.
  - key_valid is ignored.
- PAUSE:
  - start with door_closed=1 → RUN; divider is restarted.
  - stop or cancel → IDLE; cnt_clearn pulse.
  - key_valid is ignored.
- DONE:
  - beep = 1 and beep counter is cleared on entry.
  - The beep counter increments on each tick.
  - When the count reaches BEEP_TICKS → IDLE; beep = 0, cnt_clearn pulse.
  - Early exit → IDLE: cancel, start, stop, key_valid, or the door opening.
- Outside RUN: mag_on = 0 and cnt_en = 0 unconditionally.
- cnt_loadn and cnt_en are never low/high in the same cycle.
- Unused state codes → IDLE on the next edge, with a cnt_clearn pulse.

Decomposition:
- Shared package oven_pkg:
  - State enum/localparams (IDLE..DONE, 3 bits).
  - Default TICK_DIV and BEEP_TICKS constants, reused by the display and top level.
- One sub-module: tick_gen (parameter TICK_DIV; ports clock, clear, restart, tick). Width = clog2(TICK_DIV).
- FSM and output registers live in oven_timer_ctrl.

Test Plan:
All scenarios run with TICK_DIV=4 and BEEP_TICKS=3; the bench models the chain with a simple down-counter.
1. Reset: clear=1 for 2 cycles → state=0, cnt_clearn=0, mag_on=0, beep=0. After release, cnt_clearn=1 next cycle.
2. Load and run: key_valid with chain=3 s, then start with door closed.
   - cnt_loadn low for 1 cycle.
   - state goes 1 → 2.
   - cnt_en pulses at cycles 4, 8, 12 after start.
   - time_zero causes DONE; mag_on falls on the same edge.
   - beep stays high for 3 ticks (12 cycles), then IDLE with a cnt_clearn pulse.
3. Door interlock:
   - Door opens mid-RUN → PAUSE next edge; mag_on=0, no cnt_en.
   - start while the door is open → stays in PAUSE.
   - Close the door and start → RUN.
4. Zero guard:
   - start with time_zero=1 in SET → stays in SET, mag_on=0.
   - tick coincident with time_zero in RUN → no cnt_en; state=DONE.
5. Priority: cancel+start in the same cycle in SET → IDLE with a cnt_clearn pulse, no RUN.
6. Reset mid-RUN: clear=1 while mag_on=1 → mag_on=0 and state=IDLE at that edge; cnt_en never pulses afterwards.
